dual_rail_sipo: RTL and testbench

DUAL_RAIL_SIPO -- requirements
Module: dual_rail_sipo

---
 rtl/dual_rail_sipo_pkg.sv | 15 +
 rtl/valid_ready_std_if.sv | 11 +
 rtl/dual_rail_dec.sv | 13 +
 rtl/dual_rail_sipo.sv | 125 ++++++++++++
 tb/tb_dual_rail_sipo.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_rail_sipo_pkg.sv
// Shared types and constants for the dual-rail serial-in parallel-out block.
// Holds the FSM state enum and the two legal dual-rail symbol codes.
package dual_rail_sipo_pkg;

   typedef enum logic [1:0] {
      EMPTY        = 2'd0,
      COLLECT      = 2'd1,
      HOLD         = 2'd2,
      HOLD_COLLECT = 2'd3
   } sipo_state_e;

   localparam logic [1:0] DR_ONE  = 2'b01;
   localparam logic [1:0] DR_ZERO = 2'b10;

endpackage

// File: rtl/valid_ready_std_if.sv
// Plain valid/ready handshake bundle; 'in' is the receiver view, 'out' the sender view.
interface valid_ready_std_if #(
   parameter int W = 8
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport in  (input valid, input data, output ready);
   modport out (output valid, output data, input ready);
endinterface

// File: rtl/dual_rail_dec.sv
// Combinational dual-rail symbol decoder: yields the bit value and flags 00/11 as illegal.
module dual_rail_dec
   import dual_rail_sipo_pkg::*;
(
   input  logic [1:0] sym,
   output logic       bit_o,
   output logic       illegal_o
);

   assign bit_o     = (sym == DR_ONE);
   assign illegal_o = (sym != DR_ONE) && (sym != DR_ZERO);

endmodule

// File: rtl/dual_rail_sipo.sv
// Assembles dual-rail serial bits (LSB first) into DATAWIDTH-bit words behind a
// one-entry output register; illegal symbols abort the partial word and pulse err.
module dual_rail_sipo
   import dual_rail_sipo_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   valid_ready_std_if.in  din,
   input  logic           din_last,
   valid_ready_std_if.out dout,
   output logic           short_word,
   output logic           err
);

   localparam int            CW       = $clog2(DATAWIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);

   sipo_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATAWIDTH-1:0] shift_q, shift_d;
   logic [DATAWIDTH-1:0] word_q, word_d;
   logic                 short_q, short_d;
   logic                 err_q, err_d;

   logic                 sym_bit, sym_illegal;
   logic                 out_valid, in_ready;
   logic                 in_xfer, out_xfer, legal_xfer, illegal_xfer, closing;
   logic [DATAWIDTH-1:0] merged;

   dual_rail_dec u_dec (
      .sym       (din.data),
      .bit_o     (sym_bit),
      .illegal_o (sym_illegal)
   );

   assign in_xfer      = din.valid & in_ready;
   assign out_xfer     = out_valid & dout.ready;
   assign legal_xfer   = in_xfer & ~sym_illegal;
   assign illegal_xfer = in_xfer & sym_illegal;
   assign closing      = legal_xfer & (din_last | (cnt_q == LAST_IDX));
   assign merged       = shift_q | (DATAWIDTH'(sym_bit) << cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A transfer while the output is held always drains it, so HOLD never feeds a partial word into HOLD_COLLECT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (legal_xfer) state_d = closing ? HOLD : COLLECT;
         end
         COLLECT: begin
            if (illegal_xfer) state_d = EMPTY;
            else if (closing) state_d = HOLD;
         end
         HOLD: begin
            if (closing)         state_d = HOLD;
            else if (legal_xfer) state_d = COLLECT;
            else if (out_xfer)   state_d = EMPTY;
         end
         HOLD_COLLECT: begin
            if (closing)                      state_d = HOLD;
            else if (illegal_xfer)            state_d = EMPTY;
            else if (out_xfer | legal_xfer)   state_d = COLLECT;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q == HOLD) || (state_q == HOLD_COLLECT);
      in_ready  = ~out_valid | dout.ready;
   end

   assign din.ready  = in_ready;
   assign dout.valid = out_valid;
   assign dout.data  = word_q;
   assign short_word = short_q;
   assign err        = err_q;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      short_d = short_q;
      err_d   = illegal_xfer;
      if (illegal_xfer) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (closing) begin
         cnt_d   = '0;
         shift_d = '0;
         word_d  = merged;
         short_d = (cnt_q != LAST_IDX);
      end else if (legal_xfer) begin
         cnt_d   = cnt_q + CW'(1);
         shift_d = merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         short_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         short_q <= short_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dual_rail_sipo.sv
// Directed bench for dual_rail_sipo: a queue-based word model checked every cycle,
// plus literal expectations on the received word stream.
module tb_dual_rail_sipo;
   import dual_rail_sipo_pkg::*;

   localparam int DW = 8;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic din_last = 1'b0;
   logic short_word;
   logic err;

   int checks   = 0;
   int passes   = 0;
   int err_seen = 0;
   int stalls   = 0;
   logic [DW:0] rx_q[$];

   valid_ready_std_if #(.W(2))  din_if ();
   valid_ready_std_if #(.W(DW)) dout_if ();

   dual_rail_sipo #(.DATAWIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din_if),
      .din_last   (din_last),
      .dout       (dout_if),
      .short_word (short_word),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Model: one output slot plus a queue of the bits gathered so far for the current word.
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_word  = '0;
   logic          m_short = 1'b0;
   logic          m_err   = 1'b0;
   bit            m_bits[$];
   logic          exp_rdy, m_in_x;
   logic [DW-1:0] m_acc;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         checkOutput("rst_dout_valid", dout_if.valid, 0);
         checkOutput("rst_dout_data", dout_if.data, 0);
         checkOutput("rst_short", short_word, 0);
         checkOutput("rst_err", err, 0);
         checkOutput("rst_din_ready", din_if.ready, 1);
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_bits.delete();
      end else begin
         exp_rdy = !m_valid || dout_if.ready;
         checkOutput("dout_valid", dout_if.valid, m_valid);
         checkOutput("din_ready", din_if.ready, exp_rdy);
         checkOutput("err", err, m_err);
         if (m_valid) begin
            checkOutput("dout_data", dout_if.data, m_word);
            checkOutput("short_word", short_word, m_short);
         end
         if (dout_if.valid && dout_if.ready) rx_q.push_back({short_word, dout_if.data});
         if (din_if.valid && !din_if.ready) stalls++;
         if (err) err_seen++;

         m_in_x = din_if.valid && exp_rdy;
         m_err  = 1'b0;
         if (m_valid && dout_if.ready) m_valid = 1'b0;
         if (m_in_x) begin
            if (din_if.data != DR_ONE && din_if.data != DR_ZERO) begin
               m_bits.delete();
               m_err = 1'b1;
            end else begin
               m_bits.push_back(din_if.data == DR_ONE);
               if (m_bits.size() == DW || din_last) begin
                  m_acc = '0;
                  for (int i = 0; i < m_bits.size(); i++) m_acc[i] = m_bits[i];
                  m_word  = m_acc;
                  m_short = (m_bits.size() < DW);
                  m_valid = 1'b1;
                  m_bits.delete();
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] sym, input logic last);
      int guard;
      @(negedge clk);
      din_if.valid = 1'b1;
      din_if.data  = sym;
      din_last     = last;
      #1;
      guard = 0;
      while (!din_if.ready && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 100) checkOutput("din_ready_timeout", 0, 1);
   endtask

   task automatic sendWord(input logic [DW-1:0] word, input int nbits, input logic last);
      for (int i = 0; i < nbits; i++)
         applyStimulus(word[i] ? DR_ONE : DR_ZERO, last && (i == nbits - 1));
   endtask

   task automatic idle();
      @(negedge clk);
      din_if.valid = 1'b0;
      din_if.data  = 2'b00;
      din_last     = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      din_if.valid  = 1'b0;
      din_if.data   = 2'b00;
      dout_if.ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Full word 0xA5, visible one cycle after the closing transfer.
      rx_q.delete();
      sendWord(8'hA5, 8, 1'b1);
      idle();
      #1;
      checkOutput("a5_latency_valid", dout_if.valid, 1);
      checkOutput("a5_data", dout_if.data, 8'hA5);
      checkOutput("a5_short", short_word, 0);
      drain();
      checkOutput("a5_rx_count", rx_q.size(), 1);
      checkOutput("a5_rx_word", rx_q[0], 9'h0A5);

      rx_q.delete();
      sendWord(8'h03, 3, 1'b1);
      idle();
      drain();
      checkOutput("short_rx_count", rx_q.size(), 1);
      checkOutput("short_rx_word", rx_q[0], 9'h103);

      // Full close without din_last, then the next bits start a fresh word.
      rx_q.delete();
      sendWord(8'hE7, 8, 1'b0);
      sendWord(8'h05, 3, 1'b1);
      idle();
      drain();
      checkOutput("nolast_rx_count", rx_q.size(), 2);
      checkOutput("nolast_rx_w0", rx_q[0], 9'h0E7);
      checkOutput("nolast_rx_w1", rx_q[1], 9'h105);

      // Backpressure: 0x3C held while 0xC3 waits.
      rx_q.delete();
      @(negedge clk);
      dout_if.ready = 1'b0;
      sendWord(8'h3C, 8, 1'b1);
      fork
         sendWord(8'hC3, 8, 1'b1);
         begin
            repeat (5) @(negedge clk);
            checkOutput("held_3c_data", dout_if.data, 8'h3C);
            checkOutput("held_din_ready", din_if.ready, 0);
            dout_if.ready = 1'b1;
         end
      join
      idle();
      drain();
      checkOutput("bp_rx_count", rx_q.size(), 2);
      checkOutput("bp_rx_w0", rx_q[0], 9'h03C);
      checkOutput("bp_rx_w1", rx_q[1], 9'h0C3);

      // Illegal symbol aborts the partial word.
      rx_q.delete();
      err_seen = 0;
      sendWord(8'h05, 3, 1'b0);
      applyStimulus(2'b11, 1'b0);
      sendWord(8'h81, 8, 1'b1);
      idle();
      drain();
      checkOutput("illegal_err_pulses", err_seen, 1);
      checkOutput("illegal_rx_count", rx_q.size(), 1);
      checkOutput("illegal_rx_word", rx_q[0], 9'h081);

      // Reset with a held word, then again mid-word.
      rx_q.delete();
      @(negedge clk);
      dout_if.ready = 1'b0;
      sendWord(8'h66, 8, 1'b1);
      idle();
      checkOutput("held_before_rst", dout_if.valid, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", dout_if.valid, 0);
      checkOutput("rst_async_ready", din_if.ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      dout_if.ready = 1'b1;
      sendWord(8'h1F, 5, 1'b0);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sendWord(8'h5A, 8, 1'b1);
      idle();
      drain();
      checkOutput("rst_rx_count", rx_q.size(), 1);
      checkOutput("rst_rx_word", rx_q[0], 9'h05A);

      // Back-to-back words with no input bubble.
      rx_q.delete();
      stalls = 0;
      sendWord(8'h01, 8, 1'b1);
      sendWord(8'hFF, 8, 1'b1);
      idle();
      drain();
      checkOutput("b2b_stalls", stalls, 0);
      checkOutput("b2b_rx_count", rx_q.size(), 2);
      checkOutput("b2b_rx_w0", rx_q[0], 9'h001);
      checkOutput("b2b_rx_w1", rx_q[1], 9'h0FF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
